// File: rtl/coin_pulse_gen.sv
// Purpose: synchronize, debounce and jam-check two raw coin sensors; emit single-cycle half/one/reject pulses.
// Latency: a coin first sampled high at edge 0 is confirmed at edge DEB_CYCLES+1; a simultaneous 1-yuan coin follows one cycle later.
// Backpressure: none; the coin sensors cannot stall, so coins confirmed together are serialized through a one-deep deferral register.

module coin_pulse_chan #(
   parameter int DEB_CYCLES = 4,
   parameter int JAM_CYCLES = 1000,
   parameter int CNT_W      = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_ev,
   output logic o_jam
);

   typedef enum logic [2:0] {ARM, LOW, RISE, HIGH, JAM, FALL} state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] JAM_LAST = CNT_W'(JAM_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_sync;
   logic             r_jam_flag;
   logic             w_s;

   assign w_s = r_sync[1];

   // Two-flop synchronizer; resets high so a sensor stuck high through reset looks already-high.
   always_ff @(posedge clk) begin
      if (reset) r_sync <= 2'b11;
      else       r_sync <= {r_sync[0], i_raw};
   end

   // The confirming RISE->HIGH transition is the channel event, seen by the output stage on the same edge.
   assign o_ev  = (r_state == RISE) && w_s && (r_cnt == DEB_LAST);
   assign o_jam = r_jam_flag;

   // Debounce / jam-detect state machine.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ARM;
         r_cnt      <= '0;
         r_jam_flag <= 1'b0;
      end else begin
         case (r_state)
            // Wait for a debounced low before arming, so a high-at-reset sensor never fires.
            ARM: begin
               if (w_s) begin
                  r_cnt <= '0;
               end else if (r_cnt == DEB_LAST) begin
                  r_state    <= LOW;
                  r_cnt      <= '0;
                  r_jam_flag <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            LOW: begin
               if (w_s) begin
                  r_state <= RISE;
                  r_cnt   <= CNT_ONE;
               end
            end
            RISE: begin
               if (!w_s) begin
                  r_state    <= LOW;
                  r_cnt      <= '0;
                  r_jam_flag <= 1'b0;
               end else if (r_cnt == DEB_LAST) begin
                  r_state <= HIGH;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            HIGH: begin
               if (!w_s) begin
                  r_state <= FALL;
                  r_cnt   <= CNT_ONE;
               end else if (r_cnt == JAM_LAST) begin
                  r_state    <= JAM;
                  r_jam_flag <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            JAM: begin
               if (!w_s) begin
                  r_state <= FALL;
                  r_cnt   <= CNT_ONE;
               end
            end
            // Release bounce returns to HIGH without a new event; jam flag survives until LOW.
            FALL: begin
               if (w_s) begin
                  r_state <= HIGH;
                  r_cnt   <= '0;
               end else if (r_cnt == DEB_LAST) begin
                  r_state    <= LOW;
                  r_cnt      <= '0;
                  r_jam_flag <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state <= ARM;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

module coin_pulse_gen #(
   parameter int DEB_CYCLES = 4,
   parameter int JAM_CYCLES = 1000,
   parameter int CNT_W      = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic coin_half_raw,
   input  logic coin_one_raw,
   input  logic enable,
   output logic half,
   output logic one,
   output logic reject,
   output logic jam
);

   logic w_ev_h;
   logic w_ev_o;
   logic w_jam_h;
   logic w_jam_o;
   logic w_acc_h;
   logic w_acc_o;
   logic r_pend_one;

   coin_pulse_chan #(
      .DEB_CYCLES (DEB_CYCLES),
      .JAM_CYCLES (JAM_CYCLES),
      .CNT_W      (CNT_W)
   ) u_half (
      .clk   (clk),
      .reset (reset),
      .i_raw (coin_half_raw),
      .o_ev  (w_ev_h),
      .o_jam (w_jam_h)
   );

   coin_pulse_chan #(
      .DEB_CYCLES (DEB_CYCLES),
      .JAM_CYCLES (JAM_CYCLES),
      .CNT_W      (CNT_W)
   ) u_one (
      .clk   (clk),
      .reset (reset),
      .i_raw (coin_one_raw),
      .o_ev  (w_ev_o),
      .o_jam (w_jam_o)
   );

   // enable only matters in the confirmation cycle.
   assign w_acc_h = w_ev_h & enable;
   assign w_acc_o = w_ev_o & enable;

   // Registered outputs; a 1-yuan coin colliding with a 5-jiao coin is deferred one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         half       <= 1'b0;
         one        <= 1'b0;
         reject     <= 1'b0;
         jam        <= 1'b0;
         r_pend_one <= 1'b0;
      end else begin
         half       <= w_acc_h;
         one        <= (w_acc_o | r_pend_one) & ~w_acc_h;
         r_pend_one <= (w_acc_o | r_pend_one) & w_acc_h;
         reject     <= (w_ev_h | w_ev_o) & ~enable;
         jam        <= w_jam_h | w_jam_o;
      end
   end

endmodule
